mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 op_valid  in  1  the EX stage holds a HI/LO-class instruction this cycle.
REQ-005 op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NONE.
REQ-006 rs_data  in  32  first operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 rt_data  in  32  second operand: multiplier or divisor.
REQ-008 read_hi  in  1  the EX instruction is MFHI.
REQ-009 read_lo  in  1  the EX instruction is MFLO.
REQ-010 hilo_data  out  32  HI if read_hi, else LO; combinational from the registers.
REQ-011 busy  out  1  an iterative operation is in progress.
REQ-012 mult_div_stall  out  1  freeze request into the stall unit; combinational.

Function
REQ-013 States SHALL be IDLE, MUL, DIV and FIX; the state register, HI, LO and the 6-bit iteration counter SHALL be the only architectural state.
REQ-014 In IDLE with op_valid and op MULT/MULTU, the block SHALL latch the operands and enter MUL; with DIV/DIVU it SHALL enter DIV; the counter SHALL load 0.
REQ-015 In IDLE with op_valid and op MTHI, HI SHALL take rs_data at that edge; with MTLO, LO SHALL take rs_data; the block SHALL stay in IDLE.
REQ-016 Signed ops SHALL iterate on operand magnitudes and record the result signs at accept.
REQ-017 MUL SHALL perform one shift-add step per cycle; DIV SHALL perform one restoring shift-subtract step per cycle; each SHALL run exactly 32 cycles, then enter FIX.
REQ-018 FIX SHALL last one cycle: it applies the sign correction, writes HI/LO, and returns to IDLE.
REQ-019 Latency SHALL be 34 cycles: accept at edge N, HI/LO visible after edge N+34, busy high from after edge N to after edge N+34.
REQ-020 MULT/MULTU SHALL produce HI:LO = 64-bit product; signed uses two's complement.
REQ-021 DIV/DIVU SHALL produce LO = quotient and HI = remainder; signed quotients truncate toward zero and the remainder takes the dividend's sign.
REQ-022 Divide by zero SHALL complete with normal latency and give LO = 0xFFFFFFFF, HI = rs_data; it SHALL NOT raise an exception.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-024 mult_div_stall SHALL equal busy AND (read_hi OR read_lo OR (op_valid AND op in 1..6)).
REQ-025 While busy, a stalled op SHALL NOT be accepted; it SHALL be accepted in the first IDLE cycle, which is the cycle the stall drops.
REQ-026 When read_hi and read_lo are both high, hilo_data SHALL return HI.
REQ-027 While busy, HI/LO SHALL keep their pre-operation values until the FIX edge.

Reset
REQ-028 While reset_n = 0 at a rising edge, the block SHALL set state IDLE, HI = 0, LO = 0 and counter = 0; busy and mult_div_stall SHALL then read 0.
REQ-029 Reset during MUL, DIV or FIX SHALL abort the operation with no HI/LO write; the first edge after reset release SHALL be able to accept a new op.

Structure
REQ-030 The op encoding, the state encoding and ITERATIONS = 32 SHALL live in the shared core package.
REQ-031 The 33-bit adder/subtractor shared by MUL and DIV SHALL be one sub-module, add_sub_33.

Verification
REQ-032 MULT: rs = 0xFFFFFFFE, rt = 3 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA after 34 cycles; busy high for exactly 34 cycles.
REQ-033 DIVU: rs = 100, rt = 7 -> LO = 14, HI = 2; DIV: rs = -7, rt = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-034 MFLO asserted 1 cycle after a MULTU accept -> mult_div_stall high for 33 cycles, then hilo_data = the new LO in the first non-stall cycle.
REQ-035 Back-to-back MULTU then DIVU held on op_valid -> second op accepted exactly at the cycle busy falls; both results correct.
REQ-036 DIVU by zero with rs = 0x1234 -> LO = 0xFFFFFFFF, HI = 0x1234; DIV 0x80000000 by -1 -> LO = 0x80000000, HI = 0.
REQ-037 reset_n low at iteration 10 of a DIV -> next cycle busy = 0, HI = LO = 0, state IDLE; then MTHI 0xA5A5A5A5 -> HI = 0xA5A5A5A5 one edge later.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings
// plus the iteration count.
package mult_div_unit_pkg;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_unit_add_sub.sv
// 33-bit adder/subtractor shared by the multiply (add) and divide (subtract) steps.
module add_sub_33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    assign sum = a + (b ^ {33{sub}}) + 33'(sub);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up in a final cycle, MTHI/MTLO writes and MFHI/MFLO stall request.
//   state   | meaning
//   ST_IDLE | waiting; accepts mult/div, performs MTHI/MTLO
//   ST_MUL  | one shift-add step per cycle, then one terminal-count cycle
//   ST_DIV  | one restoring shift-subtract step per cycle, then terminal-count cycle
//   ST_FIX  | sign correction and HI/LO write, back to idle
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        read_hi,
    input  logic        read_lo,
    output logic [31:0] hilo_data,
    output logic        busy,
    output logic        mult_div_stall
);

    state_t             state, state_nxt;
    op_t                op_e;
    logic [31:0]        hi, lo;
    logic [CNT_W-1:0]   count;
    logic [31:0]        opnd, acc, quo;
    logic               is_div, neg_main, neg_rem;

    logic               accept_mul, accept_div, signed_op, count_done, div_ok;
    logic [31:0]        rs_mag, rt_mag;
    logic [32:0]        add_a, add_b, sum;
    logic [63:0]        prod_fix;
    logic [31:0]        quo_fix, rem_fix;

    assign op_e       = op_t'(op);
    assign signed_op  = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign accept_mul = (state == ST_IDLE) && op_valid && ((op_e == OP_MULT) || (op_e == OP_MULTU));
    assign accept_div = (state == ST_IDLE) && op_valid && ((op_e == OP_DIV) || (op_e == OP_DIVU));
    assign rs_mag     = (signed_op && rs_data[31]) ? 32'd0 - rs_data : rs_data;
    assign rt_mag     = (signed_op && rt_data[31]) ? 32'd0 - rt_data : rt_data;
    assign count_done = (count == CNT_W'(ITERATIONS));

    // Multiply adds opnd only when the current multiplier bit is set; divide
    // subtracts the divisor from the partial remainder shifted left by one.
    assign add_a = (state == ST_DIV) ? {acc, quo[31]} : {1'b0, acc};
    assign add_b = {1'b0, ((state == ST_MUL) && !quo[0]) ? 32'd0 : opnd};

    add_sub_33 u_add_sub (
        .a   (add_a),
        .b   (add_b),
        .sub (state == ST_DIV),
        .sum (sum)
    );

    assign div_ok   = !sum[32];
    assign prod_fix = neg_main ? 64'd0 - {acc, quo} : {acc, quo};
    assign quo_fix  = neg_main ? 32'd0 - quo : quo;
    assign rem_fix  = neg_rem  ? 32'd0 - acc : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_mul)      state_nxt = ST_MUL;
                else if (accept_div) state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: if (count_done) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            opnd     <= '0;
            acc      <= '0;
            quo      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (op_valid && op_e == OP_MTHI) hi <= rs_data;
                    if (op_valid && op_e == OP_MTLO) lo <= rs_data;
                    if (accept_mul || accept_div) begin
                        count  <= '0;
                        opnd   <= rt_mag;
                        quo    <= rs_mag;
                        acc    <= '0;
                        is_div <= accept_div;
                        // A zero divisor must leave the all-ones quotient unnegated.
                        neg_main <= signed_op && (rs_data[31] ^ rt_data[31])
                                    && (accept_mul || rt_data != 32'd0);
                        neg_rem  <= signed_op && rs_data[31];
                    end
                end
                ST_MUL: if (!count_done) begin
                    count <= count + 1'b1;
                    acc   <= sum[32:1];
                    quo   <= {sum[0], quo[31:1]};
                end
                ST_DIV: if (!count_done) begin
                    count <= count + 1'b1;
                    acc   <= div_ok ? sum[31:0] : add_a[31:0];
                    quo   <= {quo[30:0], div_ok};
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state != ST_IDLE);
    assign hilo_data      = read_hi ? hi : lo;
    assign mult_div_stall = busy && (read_hi || read_lo ||
                            (op_valid && (op != 3'd0) && (op != 3'd7)));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        read_hi, read_lo;
    logic [31:0] hilo_data;
    logic        busy, mult_div_stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .op_valid       (op_valid),
        .op             (op),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .read_hi        (read_hi),
        .read_lo        (read_lo),
        .hilo_data      (hilo_data),
        .busy           (busy),
        .mult_div_stall (mult_div_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: what HI/LO become after the op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (o == 3'd3) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic check_hilo(input string tag);
        read_hi = 1'b1; read_lo = 1'b0; #1;
        chk({tag, "_hi"}, hilo_data, m_hi);
        read_hi = 1'b0; read_lo = 1'b1; #1;
        chk({tag, "_lo"}, hilo_data, m_lo);
        read_hi = 1'b1; #1;
        chk({tag, "_both_hi"}, hilo_data, m_hi);
        read_hi = 1'b0; read_lo = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        int cycles;
        @(negedge clk);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (cycles == 10) begin
                read_lo = 1'b1; #1;
                chk({tag, "_lo_held"}, hilo_data, m_lo);
                chk({tag, "_stall_rd"}, 32'(mult_div_stall), 32'd1);
                read_lo = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (o >= 3'd1 && o <= 3'd4) chk({tag, "_busy_cycles"}, cycles, 34);
        else chk({tag, "_busy_cycles"}, cycles, 0);
        model(o, a, b);
        check_hilo(tag);
    endtask

    initial begin
        int cyc;
        logic [2:0] o;
        logic [31:0] a, b;
        reset_n = 1'b0; op_valid = 1'b0; op = 3'd0;
        rs_data = '0; rt_data = '0; read_hi = 1'b0; read_lo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(mult_div_stall), 32'd0);
        check_hilo("rst");
        @(negedge clk); reset_n = 1'b1;

        run_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg2x3_exp_hi", m_hi, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd4, 32'd100, 32'd7);
        run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_by0", 3'd4, 32'h1234, 32'd0);
        run_op("div_by0_neg", 3'd3, 32'h8000_1234, 32'd0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mthi", 3'd5, 32'hDEAD_BEEF, 32'd0);
        run_op("mtlo", 3'd6, 32'hCAFE_F00D, 32'd0);
        run_op("rsvd", 3'd7, 32'h1111_1111, 32'd0);

        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 15) == 0) b = 32'hFFFF_FFFF;
            run_op("rand", o, a, b);
        end

        // MFLO one cycle after a MULTU accept: stall spans the rest of the op.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; rs_data = 32'h0001_0003; rt_data = 32'h0002_0005;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        @(posedge clk); #1;
        read_lo = 1'b1; #1;
        cyc = 0;
        while (mult_div_stall && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("mflo_stall_cycles", cyc, 33);
        model(3'd2, 32'h0001_0003, 32'h0002_0005);
        chk("mflo_first_free", hilo_data, m_lo);
        read_lo = 1'b0;

        // MULTU followed by DIVU held on op_valid while busy.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; rs_data = 32'h9ABC_DEF0; rt_data = 32'h1357_9BDF;
        @(posedge clk); #1;
        op = 3'd4; rs_data = 32'hF000_0001; rt_data = 32'h0000_0123;
        #1;
        chk("b2b_stall_held", 32'(mult_div_stall), 32'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("b2b_first_cycles", cyc, 34);
        model(3'd2, 32'h9ABC_DEF0, 32'h1357_9BDF);
        chk("b2b_free_stall", 32'(mult_div_stall), 32'd0);
        read_hi = 1'b1; #1;
        chk("b2b_mul_hi", hilo_data, m_hi);
        read_hi = 1'b0; read_lo = 1'b1; #1;
        chk("b2b_mul_lo", hilo_data, m_lo);
        read_lo = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        chk("b2b_second_accept", 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("b2b_second_cycles", cyc, 34);
        model(3'd4, 32'hF000_0001, 32'h0000_0123);
        check_hilo("b2b_div");

        // Reset in the middle of a divide aborts it and clears HI/LO.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; rs_data = 32'h7654_3210; rt_data = 32'h0000_0033;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        check_hilo("abort");
        @(negedge clk); reset_n = 1'b1;
        op_valid = 1'b1; op = 3'd5; rs_data = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        chk("abort_mthi_busy", 32'(busy), 32'd0);
        m_hi = 32'hA5A5_A5A5;
        check_hilo("abort_mthi");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
